mem_sram_ctrl: RTL
==================

// Module: mem_sram_ctrl
// PURPOSE
//  MEM-stage controller between the ARM EXE/MEM pipeline register and the off-chip 16-bit SRAM.
//  Splits each 32-bit load/store into two 16-bit SRAM accesses: low half, then high half.
//  Holds ready low until the access completes; the pipeline uses ~ready as SRAM_Freeze.
//  read_data feeds Mem_read_value_in of the MEM/WB register.
// PARAMETERS
//  WAIT_CYCLES  2        extra cycles per half-access (each half lasts WAIT_CYCLES+1 cycles)
//  BASE_ADDR    32'd1024 data-memory base; subtracted from address before mapping
//  SRAM_AW      18       SRAM half-word address width
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high
//  rd_en        in   1       load request (MEM_R_EN); held stable while ready=0
//  wr_en        in   1       store request (MEM_W_EN); held stable while ready=0
//  address      in   32      byte address (ALU result); held stable while ready=0
//  write_data   in   32      store data (Val_Rm); held stable while ready=0
//  read_data    out  32      last completed load word
//  ready        out  1       1 = no access pending or access done this cycle
//  SRAM_DQ      inout 16     SRAM data bus
//  SRAM_ADDR    out  SRAM_AW SRAM half-word address
//  SRAM_WE_N    out  1       write enable, active-low
//  SRAM_OE_N    out  1       output enable, active-low
//  SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out 1 each; tied 0
// BEHAVIOUR
//  eff = address - BASE_ADDR; word index w = eff[SRAM_AW:2]; eff[1:0] ignored (word-aligned only).
//  FSM states: IDLE, LOW, HIGH, DONE. Phase counter cnt is 0..WAIT_CYCLES.
//   IDLE: rd_en|wr_en -> LOW with cnt=0; otherwise stay in IDLE.
//   LOW:  cnt==WAIT_CYCLES -> HIGH with cnt=0; otherwise cnt++.
//   HIGH: cnt==WAIT_CYCLES -> DONE; otherwise cnt++.
//   DONE: -> IDLE unconditionally.
//  ready is combinational:
//   IDLE: ~(rd_en|wr_en).  LOW/HIGH: 0.  DONE: 1.
//  Latency: request first visible in cycle 0; ready=1 in cycle 2*(WAIT_CYCLES+1)+1 (7 at default).
//  Back-to-back requests:
//   - after DONE, a new request is seen in IDLE next cycle; ready=0 that cycle.
//   - no request is ever skipped or double-issued.
//  rd_en & wr_en both 1: treated as a write; read_data is not updated.
//  SRAM_ADDR:
//   - LOW: {w,1'b0}.  HIGH: {w,1'b1}.  IDLE/DONE: 0.
//   - address wrap modulo 2^SRAM_AW; no range checking.
//  Write:
//   - SRAM_WE_N=0 in LOW and HIGH.
//   - SRAM_DQ = write_data[15:0] in LOW, write_data[31:16] in HIGH; otherwise 16'bz.
//   - SRAM_OE_N=1.
//  Read:
//   - SRAM_WE_N=1; SRAM_OE_N=0 in LOW/HIGH, else 1; SRAM_DQ=z.
//   - read_data[15:0] latched at the clock edge that leaves LOW.
//   - read_data[31:16] latched at the clock edge that leaves HIGH.
//   - read_data is therefore valid in DONE and held until the next read updates it.
//  Reset (any time, including mid-access):
//   - state=IDLE, cnt=0, read_data=0; ready follows IDLE rule.
//   - SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ=z, SRAM_ADDR=0.
//   - an aborted write may leave a half-written word; accepted.
// STRUCTURE
//  mem_pkg:
//   - enum mem_state_t {IDLE,LOW,HIGH,DONE}
//   - SRAM_DW=16 and default BASE_ADDR constant, shared with the SRAM behavioural model.
//  Sub-module sram_phase_counter:
//   - inputs clk, reset, clear, en; output last = (cnt==WAIT_CYCLES).
//  FSM, address mux, tri-state driver and read_data latch live in mem_sram_ctrl.
// TESTING (bench includes 16-bit SRAM model with WAIT_CYCLES-matched timing)
//  1 Reset, no request -> ready=1, read_data=0, WE_N=1, OE_N=1, DQ=z.
//  2 Store 0xDEADBEEF to 1024 -> ready low 7 cycles, high in cycle 7;
//    SRAM[0]=0xBEEF, SRAM[1]=0xDEAD.
//  3 Load from 1024 after test 2 -> read_data=0xDEADBEEF in DONE; ADDR 0 then 1.
//  4 Store 0x12345678 to 1032, then load from 1032 immediately ->
//    each access 7 cycles, 1 IDLE cycle between them, read_data=0x12345678.
//  5 Reset asserted in HIGH of a load -> same cycle: IDLE, DQ=z, read_data=0;
//    next request starts cleanly.
//  6 WAIT_CYCLES=0 build, load from 1028 -> ready high 3 cycles after request,
//    correct word returned.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller and its SRAM model.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } mem_state_t;

  localparam int unsigned SRAM_DW           = 16;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  // Phase counter width; at least one bit even when there are no wait cycles.
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Counts the cycles of one SRAM half-access; last flags the final cycle of the phase.
module sram_phase_counter
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int unsigned     CW       = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WAIT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller: splits each 32-bit load/store into low then high 16-bit SRAM accesses.
module mem_sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  mem_state_t         state_q, state_d;
  logic [31:0]        read_data_q, read_data_d;
  logic               last, cnt_clear, cnt_en;
  logic               req, is_write, is_read;
  logic               access, phase_hi;
  logic [31:0]        eff;
  logic [SRAM_AW-2:0] word_idx;
  logic               unused_eff_bits;

  // A simultaneous read and write request is handled as a write only.
  assign req      = rd_en | wr_en;
  assign is_write = wr_en;
  assign is_read  = rd_en & ~wr_en;

  assign eff             = address - BASE_ADDR;
  assign word_idx        = eff[SRAM_AW:2];
  assign unused_eff_bits = ^{eff[31:SRAM_AW+1], eff[1:0]};

  sram_phase_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_phase_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(cnt_clear),
    .en   (cnt_en),
    .last (last)
  );

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    cnt_clear = 1'b1;
    cnt_en    = 1'b0;
    access    = 1'b0;
    phase_hi  = 1'b0;
    SRAM_ADDR = '0;
    case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) state_d = LOW;
      end
      LOW: begin
        access    = 1'b1;
        SRAM_ADDR = {word_idx, 1'b0};
        if (last) begin
          state_d = HIGH;
        end else begin
          cnt_clear = 1'b0;
          cnt_en    = 1'b1;
        end
      end
      HIGH: begin
        access    = 1'b1;
        phase_hi  = 1'b1;
        SRAM_ADDR = {word_idx, 1'b1};
        if (last) begin
          state_d = DONE;
        end else begin
          cnt_clear = 1'b0;
          cnt_en    = 1'b1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Each half is captured on the edge that ends its phase, when the SRAM data has settled.
  always_comb begin
    read_data_d = read_data_q;
    if (is_read && last) begin
      if (state_q == LOW)  read_data_d[15:0]  = SRAM_DQ;
      if (state_q == HIGH) read_data_d[31:16] = SRAM_DQ;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;
  assign SRAM_WE_N = ~(access & is_write);
  assign SRAM_OE_N = ~(access & is_read);
  assign SRAM_DQ   = (access & is_write) ? (phase_hi ? write_data[31:16] : write_data[15:0]) : 'z;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule
